ahb_tube_slave: RTL and testbench

//  AHB slave at 0x2000_0000 that consumes the single-word NONSEQ writes issued by
//  the test masters and buffers the low byte of each write in a character FIFO.

---
 rtl/tube_pkg.sv | 39 +++
 rtl/ahb_tube_slave_if.sv | 39 +++
 rtl/tube_fifo.sv | 82 ++++++++
 rtl/ahb_tube_slave.sv | 124 ++++++++++++
 tb/tb_ahb_tube_slave.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tube_pkg
//  Description : Shared constants for the AHB tube slave: AHB transfer and
//                response codes, register offsets, base address, data-phase
//                FSM encoding and the STATUS word packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tube_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_BUSY   = 2'b01;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HTRANS_SEQ    = 2'b11;

    localparam logic [1:0]  HRESP_OKAY    = 2'b00;

    // Offsets are kept 32 bits wide; users slice the decoded low bits.
    localparam logic [31:0] OFF_DATA      = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS    = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL      = 32'h0000_0008;

    localparam logic [31:0] TUBE_BASE     = 32'h2000_0000;

    // Data-phase FSM encoding
    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_WR         = 2'd1;
    localparam logic [1:0]  ST_RD         = 2'd2;
    localparam logic [1:0]  ST_WAIT       = 2'd3;

    // STATUS: level in [7:0], full in [8], empty in [9]
    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       full,
                                                input logic       empty);
        return {22'b0, empty, full, level};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_tube_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_tube_slave_if
//  Description : AHB slave-side bus signals plus the character stream that
//                leaves the tube.
//                master modport : bus/decoder side and character sink
//                slave  modport : the tube slave itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_tube_slave_if;

    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [31:0] HWDATAS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HWDATAS, HREADYS,
        output char_ready,
        input  HREADYOUTS, HRESPS, HRDATAS, char_data, char_valid
    );

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HWDATAS, HREADYS,
        input  char_ready,
        output HREADYOUTS, HRESPS, HRDATAS, char_data, char_valid
    );

endinterface
`default_nettype wire

// File: rtl/tube_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tube_fifo
//  Description : Synchronous FIFO with occupancy count. A push while full and
//                a pop while empty are ignored; there is no write-to-read
//                bypass, so a push into an empty FIFO becomes visible at head
//                on the following cycle.
//  Ports       : clk, rst_n (sync, active-low), push/din, pop,
//                full, empty, level, head
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           din,
    input  wire logic                       pop,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          level,
    output logic [WIDTH-1:0]                head
);

    localparam int              PW           = $clog2(DEPTH);
    localparam int              LW           = PW + 1;
    localparam logic [LW-1:0]   C_FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (level_q == C_FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_tube_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_tube_slave
//  Description : AHB "tube" slave. Writes to DATA push the low byte into a
//                character FIFO that drains over a valid/ready stream. A
//                write to DATA while the FIFO is full stalls the bus until a
//                slot frees up. STATUS reports level/full/empty; CTRL bit0
//                gates the drain.
//  Ports       : HCLK    - clock
//                HRESETn - synchronous active-low reset
//                bus     - AHB slave signals and character stream
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_tube_slave
    import tube_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  wire logic        HCLK,
    input  wire logic        HRESETn,
    ahb_tube_slave_if.slave  bus
);

    localparam int            LW           = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] C_OFF_DATA   = OFF_DATA[AW-1:0];
    localparam logic [AW-1:0] C_OFF_STATUS = OFF_STATUS[AW-1:0];
    localparam logic [AW-1:0] C_OFF_CTRL   = OFF_CTRL[AW-1:0];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] off_q,   off_d;
    logic          drain_en_q, drain_en_d;

    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [7:0]    w_head;
    logic          w_data_wr;
    logic          w_stall;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic          w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.HSIZES, bus.HADDRS[31:AW]};

    // Only NONSEQ/SEQ carry an address phase worth a data phase.
    assign w_accept  = bus.HSELS & bus.HREADYS &
                       ((bus.HTRANSS == HTRANS_NONSEQ) | (bus.HTRANSS == HTRANS_SEQ));

    // A DATA write is pending either on its first data-phase cycle or while
    // parked in WAIT. It completes only when the FIFO (as registered) has room.
    assign w_data_wr = ((state_q == ST_WR) & (off_q == C_OFF_DATA)) | (state_q == ST_WAIT);
    assign w_stall   = w_data_wr & w_full;
    assign w_push    = w_data_wr & ~w_full;

    assign bus.char_valid = ~w_empty & drain_en_q;
    assign bus.char_data  = w_empty ? 8'h00 : w_head;
    assign w_pop          = bus.char_valid & bus.char_ready;

    assign bus.HREADYOUTS = ~w_stall;
    assign bus.HRESPS     = HRESP_OKAY;

    always_comb begin
        bus.HRDATAS = 32'h0;
        if (state_q == ST_RD) begin
            case (off_q)
                C_OFF_STATUS: bus.HRDATAS = status_word(8'(w_level), w_full, w_empty);
                C_OFF_CTRL:   bus.HRDATAS = {31'h0, drain_en_q};
                default:      bus.HRDATAS = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        drain_en_d = drain_en_q;

        if ((state_q == ST_WR) && (off_q == C_OFF_CTRL)) begin
            drain_en_d = bus.HWDATAS[0];
        end

        if (w_stall) begin
            state_d = ST_WAIT;
        end else if (w_accept) begin
            // Current data phase completes this cycle, so the next address
            // phase is taken in the same cycle (pipelined back-to-back).
            state_d = bus.HWRITES ? ST_WR : ST_RD;
            off_d   = bus.HADDRS[AW-1:0];
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            drain_en_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            drain_en_q <= drain_en_d;
        end
    end

    tube_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (w_push),
        .din   (bus.HWDATAS[7:0]),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level),
        .head  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_tube_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_tube_slave
//  Description : Self-checking bench for ahb_tube_slave. A queue-based model
//                of the tube is compared against the DUT on every cycle;
//                directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_tube_slave;
    import tube_pkg::*;

    localparam int DEPTH = 8;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_tube_slave_if bus();
    assign bus.HREADYS = bus.HREADYOUTS;   // single slave on the bus

    ahb_tube_slave #(.DEPTH(DEPTH), .AW(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];          // characters held by the tube, head first
    bit         m_drain = 1'b1;
    int         m_pend  = 0;    // 0 none, 1 write data phase, 2 read data phase
    logic [3:0] m_off   = 4'h0;
    bit         m_live  = 1'b0;

    function automatic bit m_full();  return mq.size() == DEPTH; endfunction
    function automatic bit m_empty(); return mq.size() == 0;     endfunction
    function automatic bit m_valid(); return !m_empty() && m_drain; endfunction
    function automatic bit m_hready();
        return !(m_pend == 1 && m_off == 4'h0 && m_full());
    endfunction
    function automatic logic [31:0] m_rdata();
        if (m_off == 4'h4)
            return mq.size() + (m_full() ? 32'h100 : 32'h0) + (m_empty() ? 32'h200 : 32'h0);
        if (m_off == 4'h8)
            return {31'h0, m_drain};
        return 32'h0;
    endfunction

    always @(posedge HCLK) begin : model_upd
        bit rdy, pop, push, nd;
        if (!HRESETn) begin
            mq.delete();
            m_drain = 1'b1;
            m_pend  = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            rdy  = m_hready();
            pop  = m_valid() && bus.char_ready;
            push = (m_pend == 1) && (m_off == 4'h0) && !m_full();
            nd   = (m_pend == 1 && m_off == 4'h8) ? bus.HWDATAS[0] : m_drain;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(bus.HWDATAS[7:0]);
            m_drain = nd;
            if (rdy) begin
                if (bus.HSELS && bus.HTRANSS[1]) begin
                    m_pend = bus.HWRITES ? 1 : 2;
                    m_off  = bus.HADDRS[3:0];
                end else begin
                    m_pend = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge HCLK) begin
        if (m_live) begin
            chk("hready",     {31'h0, bus.HREADYOUTS}, {31'h0, m_hready()});
            chk("hresp",      {30'h0, bus.HRESPS},     {30'h0, HRESP_OKAY});
            chk("char_valid", {31'h0, bus.char_valid}, {31'h0, m_valid()});
            if (m_valid())
                chk("char_data", {24'h0, bus.char_data}, {24'h0, mq[0]});
            if (m_pend == 2)
                chk("hrdata", bus.HRDATAS, m_rdata());
        end
    end

    // Record every character the sink accepts
    logic [7:0] drained[$];
    always @(negedge HCLK) begin
        if (HRESETn && bus.char_valid && bus.char_ready)
            drained.push_back(bus.char_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        bus.HSELS   = 1'b0;
        bus.HTRANSS = HTRANS_IDLE;
        bus.HWRITES = 1'b0;
        bus.HADDRS  = 32'h0;
        bus.HSIZES  = 3'b010;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] off);
        bus.HSELS   = 1'b1;
        bus.HTRANSS = HTRANS_NONSEQ;
        bus.HWRITES = wr;
        bus.HADDRS  = TUBE_BASE | off;
        bus.HSIZES  = 3'b010;
    endtask

    // Finish the current cycle once HREADYOUTS is high; returns just after the edge.
    task automatic finish_cycle(output logic [31:0] rd);
        rd = 32'h0;
        for (int k = 0; k < 200; k++) begin
            @(negedge HCLK);
            if (bus.HREADYOUTS) begin
                rd = bus.HRDATAS;
                @(posedge HCLK);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: actual HREADYOUTS low for 200 cycles required high");
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] off, input logic [31:0] data);
        logic [31:0] d;
        addr_phase(1'b1, off);
        finish_cycle(d);
        idle_bus();
        bus.HWDATAS = data;
        finish_cycle(d);
    endtask

    task automatic ahb_read(input logic [31:0] off, output logic [31:0] rd);
        logic [31:0] d;
        addr_phase(1'b0, off);
        finish_cycle(d);
        idle_bus();
        finish_cycle(rd);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [31:0] rd;
        logic [7:0]  exp_q[$];
        idle_bus();
        bus.HWDATAS    = 32'h0;
        bus.char_ready = 1'b0;
        HRESETn        = 1'b0;
        step(3);
        @(negedge HCLK);
        chk("rst_hready",     {31'h0, bus.HREADYOUTS}, 32'h1);
        chk("rst_char_valid", {31'h0, bus.char_valid}, 32'h0);
        chk("rst_char_data",  {24'h0, bus.char_data},  32'h0);
        chk("rst_hrdata",     bus.HRDATAS,             32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        step(1);

        // 1: single write appears on the stream the next cycle
        bus.char_ready = 1'b1;
        ahb_write(32'h0, 32'h0000_AB31);
        @(negedge HCLK);
        chk("t1_valid", {31'h0, bus.char_valid}, 32'h1);
        chk("t1_data",  {24'h0, bus.char_data},  32'h31);
        @(posedge HCLK); #1;
        step(2);

        // 2: fill, stall on the ninth write, release by one pop, order kept
        bus.char_ready = 1'b0;
        drained.delete();
        for (int i = 0; i < 8; i++) ahb_write(32'h0, 32'h41 + i);
        ahb_read(32'h4, rd);
        chk("t2_status_full", rd, 32'h108);
        addr_phase(1'b1, 32'h0);
        finish_cycle(rd);
        idle_bus();
        bus.HWDATAS = 32'h49;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("t2_stall", {31'h0, bus.HREADYOUTS}, 32'h0);
            @(posedge HCLK); #1;
        end
        bus.char_ready = 1'b1;
        @(negedge HCLK);
        chk("t2_stall_pop_cycle", {31'h0, bus.HREADYOUTS}, 32'h0);
        @(posedge HCLK); #1;
        bus.char_ready = 1'b0;
        @(negedge HCLK);
        chk("t2_release", {31'h0, bus.HREADYOUTS}, 32'h1);
        @(posedge HCLK); #1;
        ahb_read(32'h4, rd);
        chk("t2_status_refull", rd, 32'h108);
        bus.char_ready = 1'b1;
        step(12);
        bus.char_ready = 1'b0;
        chk("t2_drain_count", drained.size(), 32'd9);
        for (int i = 0; i < 9 && i < drained.size(); i++)
            chk("t2_order", {24'h0, drained[i]}, 32'h41 + i);

        // 3: drain_en gates the stream
        drained.delete();
        ahb_write(32'h8, 32'h0);
        bus.char_ready = 1'b1;
        ahb_write(32'h0, 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("t3_gated", {31'h0, bus.char_valid}, 32'h0);
        end
        @(posedge HCLK); #1;
        ahb_read(32'h8, rd);
        chk("t3_ctrl0", rd, 32'h0);
        ahb_read(32'h4, rd);
        chk("t3_status1", rd, 32'h1);
        ahb_write(32'h8, 32'h1);
        step(3);
        chk("t3_count", drained.size(), 32'd1);
        if (drained.size() > 0) chk("t3_char", {24'h0, drained[0]}, 32'h55);
        ahb_read(32'h8, rd);
        chk("t3_ctrl1", rd, 32'h1);

        // 4: pipelined writes with concurrent drain hold the level at 3
        bus.char_ready = 1'b0;
        drained.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            ahb_write(32'h0, 32'h61 + i);
            exp_q.push_back(8'h61 + 8'(i));
        end
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) addr_phase(1'b1, 32'h0);
            else        idle_bus();
            if (i > 0) begin
                bus.HWDATAS = 32'h70 + i - 1;
                exp_q.push_back(8'h70 + 8'(i - 1));
            end
            bus.char_ready = (i > 0);
            finish_cycle(rd);
        end
        bus.char_ready = 1'b0;
        ahb_read(32'h4, rd);
        chk("t4_level3", rd, 32'h3);
        bus.char_ready = 1'b1;
        step(6);
        bus.char_ready = 1'b0;
        chk("t4_count", drained.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
            chk("t4_order", {24'h0, drained[i]}, {24'h0, exp_q[i]});

        // 5: IDLE/BUSY/unselected transfers have no effect
        bus.HWDATAS = 32'h99;
        bus.HSELS   = 1'b1;
        bus.HWRITES = 1'b1;
        bus.HADDRS  = TUBE_BASE;
        bus.HTRANSS = HTRANS_IDLE;
        step(2);
        bus.HTRANSS = HTRANS_BUSY;
        step(1);
        bus.HSELS   = 1'b0;
        bus.HTRANSS = HTRANS_NONSEQ;
        step(2);
        idle_bus();
        step(1);
        ahb_read(32'h4, rd);
        chk("t5_status_empty", rd, 32'h200);
        ahb_read(32'hC, rd);
        chk("t5_other_off", rd, 32'h0);
        ahb_read(32'h0, rd);
        chk("t5_data_read", rd, 32'h0);

        // 6: reset while stalled drops the write
        for (int i = 0; i < 8; i++) ahb_write(32'h0, 32'h11 + i);
        addr_phase(1'b1, 32'h0);
        finish_cycle(rd);
        idle_bus();
        bus.HWDATAS = 32'h77;
        @(negedge HCLK);
        chk("t6_stalled", {31'h0, bus.HREADYOUTS}, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        step(2);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("t6_hready", {31'h0, bus.HREADYOUTS}, 32'h1);
        chk("t6_valid",  {31'h0, bus.char_valid}, 32'h0);
        @(posedge HCLK); #1;
        ahb_read(32'h4, rd);
        chk("t6_status_empty", rd, 32'h200);
        ahb_read(32'h8, rd);
        chk("t6_ctrl_reset", rd, 32'h1);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
